// File: rtl/dcache_refill_engine.sv
// dcache_refill_engine
// Services read-miss and write-miss repair requests from the L1 data-cache
// controller. It issues one block-aligned read to the next memory level,
// assembles the returned beats into a line buffer, and hands the whole block
// back with a full byte mask and a one-cycle repair_resolved pulse. The core
// is stalled for the whole repair window.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   read_repair_request      read miss, address on missed_addr
//   write_miss_repair        write miss, address on write_miss_addr
//   repair_resolved          one-cycle pulse, fill_* valid in the same cycle
//   fill_addr/data/mask      returned block (address is block-aligned)
//   core_stall               high while a repair is in flight
//   mem_req_*                block read request to memory (valid/ready)
//   mem_resp_*               response beats, lowest beat first
//   protocol_err             sticky, a beat arrived outside FILL
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a miss; read wins over write
// REQ     | memory request presented, waiting for ready
// FILL    | collecting NBEATS beats into the line buffer
// RESOLVE | one-cycle handback of the block to the controller
module dcache_refill_engine #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BITS  = 1024,
  parameter int BEAT_BITS   = 128,
  parameter int OFFSET_BITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_repair_request,
  input  logic                    write_miss_repair,
  input  logic [ADDR_W-1:0]       missed_addr,
  input  logic [ADDR_W-1:0]       write_miss_addr,
  output logic                    repair_resolved,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [BLOCK_BITS-1:0]   fill_data,
  output logic [BLOCK_BITS/8-1:0] fill_mask,
  output logic                    core_stall,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [BEAT_BITS-1:0]    mem_resp_data,
  output logic                    protocol_err
);

  localparam int NBEATS = BLOCK_BITS / BEAT_BITS;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_FILL    = 2'd2,
    S_RESOLVE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0]   line_q, line_d;
  // Separate output copy so fill_data keeps the last block while the
  // line buffer is being overwritten by the next repair.
  logic [BLOCK_BITS-1:0]   fill_data_q, fill_data_d;
  logic [ADDR_W-1:0]       fill_addr_q, fill_addr_d;
  logic                    err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      fill_data_q <= '0;
      fill_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      fill_data_q <= fill_data_d;
      fill_addr_q <= fill_addr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    fill_data_d = fill_data_q;
    fill_addr_d = fill_addr_q;
    // Beats outside FILL are dropped; only the error flag records them.
    err_d       = err_q | (mem_resp_valid && (state_q != S_FILL));

    case (state_q)
      S_IDLE: begin
        if (read_repair_request) begin
          addr_d  = missed_addr & ALIGN_MASK;
          state_d = S_REQ;
        end else if (write_miss_repair) begin
          addr_d  = write_miss_addr & ALIGN_MASK;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_resp_valid) begin
          line_d[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] = mem_resp_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            // line_d already includes the final beat here.
            fill_data_d = line_d;
            fill_addr_d = addr_q;
            state_d     = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign repair_resolved = (state_q == S_RESOLVE);
  assign fill_mask       = (state_q == S_RESOLVE) ? '1 : '0;
  assign fill_data       = fill_data_q;
  assign fill_addr       = fill_addr_q;
  assign core_stall      = (state_q != S_IDLE);
  assign mem_req_valid   = (state_q == S_REQ);
  assign mem_req_addr    = addr_q;
  assign protocol_err    = err_q;

endmodule
